// File: rtl/led_step_ctrl_if.sv
// Key inputs and chaser outputs of the LED step controller.
// Optional pause key / paused flag exist only when LED_STEP_PAUSE_EN is defined.
interface led_step_ctrl_if;
    logic       key_speed_n;
    logic       key_dir_n;
`ifdef LED_STEP_PAUSE_EN
    logic       key_pause_n;
    logic       paused;
`endif
    logic [1:0] pos;
    logic       dir;
    logic [1:0] speed;
    logic       step_tick;

    // Board / bench side: drives the keys, observes the chaser state
    modport master (
        output key_speed_n,
        output key_dir_n,
        input  pos,
        input  dir,
        input  speed,
        input  step_tick
`ifdef LED_STEP_PAUSE_EN
        ,
        output key_pause_n,
        input  paused
`endif
    );

    // Controller side
    modport slave (
        input  key_speed_n,
        input  key_dir_n,
        output pos,
        output dir,
        output speed,
        output step_tick
`ifdef LED_STEP_PAUSE_EN
        ,
        input  key_pause_n,
        output paused
`endif
    );
endinterface

// File: rtl/led_step_ctrl.sv
// LED chaser step controller: debounced speed/direction keys drive a
// power-of-two prescaler that steps a 2-bit LED position up or down.
// Optional pause key enabled by defining LED_STEP_PAUSE_EN.
module led_step_ctrl #(
    parameter int STEP_SHIFT_MAX = 25,
    parameter int DEB_CYC        = 1000000
) (
    input  logic           clk_50M,
    input  logic           rst,
    led_step_ctrl_if.slave bus
);

`ifdef LED_STEP_PAUSE_EN
    localparam int NKEY = 3;
`else
    localparam int NKEY = 2;
`endif
    localparam int KEY_SPEED = 0;
    localparam int KEY_DIR   = 1;

    localparam int PS_W  = STEP_SHIFT_MAX + 1;
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Prescaler terminal counts for speed levels 0..3 (period 2^(MAX-speed))
    localparam logic [PS_W-1:0] LIM0 = PS_W'((64'd1 << STEP_SHIFT_MAX) - 64'd1);
    localparam logic [PS_W-1:0] LIM1 = PS_W'((64'd1 << (STEP_SHIFT_MAX - 1)) - 64'd1);
    localparam logic [PS_W-1:0] LIM2 = PS_W'((64'd1 << (STEP_SHIFT_MAX - 2)) - 64'd1);
    localparam logic [PS_W-1:0] LIM3 = PS_W'((64'd1 << (STEP_SHIFT_MAX - 3)) - 64'd1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} deb_state_t;

    // Position advance with modulo-4 wrap in either direction
    function automatic logic [1:0] pos_step(input logic [1:0] cur, input logic down);
        pos_step = down ? (cur - 2'd1) : (cur + 2'd1);
    endfunction

    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] sync_p0;
    logic [NKEY-1:0] sync_p1;
    logic [NKEY-1:0] press;

    logic [PS_W-1:0] presc;
    logic [PS_W-1:0] presc_limit;
    logic [1:0]      pos_q;
    logic            dir_q;
    logic [1:0]      speed_q;
    logic            run;
    logic            tick;

    assign key_raw[KEY_SPEED] = bus.key_speed_n;
    assign key_raw[KEY_DIR]   = bus.key_dir_n;

`ifdef LED_STEP_PAUSE_EN
    localparam int KEY_PAUSE = 2;
    logic paused_q;
    assign key_raw[KEY_PAUSE] = bus.key_pause_n;
    assign run                = ~paused_q;
    assign bus.paused         = paused_q;

    // Pause flag toggles on each debounced pause press
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst)
            paused_q <= 1'b0;
        else if (press[KEY_PAUSE])
            paused_q <= ~paused_q;
    end
`else
    assign run = 1'b1;
`endif

    // Two-flop synchronizer for the asynchronous keys (idle level is high)
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= key_raw;
            sync_p1 <= sync_p0;
        end
    end

    // One debounce FSM per key; counter holds the number of stable cycles seen
    for (genvar k = 0; k < NKEY; k++) begin : g_deb
        deb_state_t       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             lvl;
        logic             press_k;

        assign lvl      = sync_p1[k];
        assign press[k] = press_k;

        // State register
        always_ff @(posedge clk_50M or negedge rst) begin
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Next-state: low must persist DEB_CYC cycles to press, high to release
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            case (state_q)
                IDLE: begin
                    if (!lvl) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (lvl)
                        state_d = IDLE;
                    else if (cnt_q == CNT_LAST)
                        state_d = HELD;
                    else
                        cnt_d = cnt_q + CNT_ONE;
                end
                HELD: begin
                    if (lvl) begin
                        state_d = REL_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                REL_WAIT: begin
                    if (!lvl)
                        state_d = HELD;
                    else if (cnt_q == CNT_LAST)
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q + CNT_ONE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Output: single press pulse on the cycle the low level is confirmed
        always_comb begin
            press_k = (state_q == PRESS_WAIT) && !lvl && (cnt_q == CNT_LAST);
        end
    end

    // Terminal count for the current speed level
    always_comb begin
        case (speed_q)
            2'd0:    presc_limit = LIM0;
            2'd1:    presc_limit = LIM1;
            2'd2:    presc_limit = LIM2;
            default: presc_limit = LIM3;
        endcase
    end

    assign tick = run && (presc == presc_limit);

    // Prescaler: a speed press restarts the period even when frozen
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst)
            presc <= '0;
        else if (press[KEY_SPEED])
            presc <= '0;
        else if (tick)
            presc <= '0;
        else if (run)
            presc <= presc + PS_W'(1);
    end

    // Speed level, direction and position; a tick always uses the old dir
    always_ff @(posedge clk_50M or negedge rst) begin
        if (!rst) begin
            speed_q <= 2'd0;
            dir_q   <= 1'b0;
            pos_q   <= 2'd0;
        end else begin
            if (press[KEY_SPEED])
                speed_q <= speed_q + 2'd1;
            if (press[KEY_DIR])
                dir_q <= ~dir_q;
            if (tick)
                pos_q <= pos_step(pos_q, dir_q);
        end
    end

    assign bus.pos       = pos_q;
    assign bus.dir       = dir_q;
    assign bus.speed     = speed_q;
    assign bus.step_tick = tick;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Table-driven bench for led_step_ctrl with STEP_SHIFT_MAX=6, DEB_CYC=4.
// Cycle index 0 is the cycle in which reset is released (prescaler = 0);
// each row is compared at the falling edge of its cycle. A key driven low at
// cycle c yields its press event in cycle c+5 when held for 4 cycles.
module tb_led_step_ctrl;
    localparam int SSM = 6;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led_step_ctrl_if bus();

    led_step_ctrl #(.STEP_SHIFT_MAX(SSM), .DEB_CYC(DEB)) dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         test;
        int         cyc;
        logic       tick;
        logic [1:0] pos;
        logic       dir;
        logic [1:0] speed;
        logic       paused;
        int         nticks;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void add(input int t, input int c, input logic tk, input logic [1:0] p,
                                input logic d, input logic [1:0] s, input logic pa, input int n);
        vec_t v;
        v.test = t; v.cyc = c; v.tick = tk; v.pos = p;
        v.dir = d; v.speed = s; v.paused = pa; v.nticks = n;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic inr(input int i, input int a, input int b);
        return (i >= a) && (i <= b);
    endfunction

    // Key stimulus per test: 1 means the key is held low in that cycle
    function automatic logic key_low(input int t, input int key, input int i);
        case (t)
            1: return key == 0 && (inr(i, 0, 3) || inr(i, 7, 16));
            2: return key == 1 && inr(i, 186, 189);
            3: return key == 0 && (inr(i, 0, 3) || inr(i, 70, 73) ||
                                   inr(i, 108, 111) || inr(i, 130, 133));
            4: return key == 0 && inr(i, 200, 203);
            5: return key == 2 && (inr(i, 70, 73) || inr(i, 580, 583));
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_test(input int t);
        int last;
        int nt;
        last = -1;
        foreach (vecs[r]) if (vecs[r].test == t && vecs[r].cyc > last) last = vecs[r].cyc;
        rst = 1'b0;
        bus.key_speed_n = 1'b1;
        bus.key_dir_n   = 1'b1;
`ifdef LED_STEP_PAUSE_EN
        bus.key_pause_n = 1'b1;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;
        nt = 0;
        for (int i = 0; i <= last; i++) begin
            if (i > 0) @(negedge clk);
            if (bus.step_tick) nt++;
            foreach (vecs[r]) begin
                if (vecs[r].test == t && vecs[r].cyc == i) begin
                    check($sformatf("t%0d c%0d step_tick", t, i), int'(bus.step_tick), int'(vecs[r].tick));
                    check($sformatf("t%0d c%0d pos", t, i), int'(bus.pos), int'(vecs[r].pos));
                    check($sformatf("t%0d c%0d dir", t, i), int'(bus.dir), int'(vecs[r].dir));
                    check($sformatf("t%0d c%0d speed", t, i), int'(bus.speed), int'(vecs[r].speed));
                    check($sformatf("t%0d c%0d tick_count", t, i), nt, vecs[r].nticks);
`ifdef LED_STEP_PAUSE_EN
                    check($sformatf("t%0d c%0d paused", t, i), int'(bus.paused), int'(vecs[r].paused));
`endif
                end
            end
            bus.key_speed_n = ~key_low(t, 0, i);
            bus.key_dir_n   = ~key_low(t, 1, i);
`ifdef LED_STEP_PAUSE_EN
            bus.key_pause_n = ~key_low(t, 2, i);
`endif
            rst = !(t == 4 && i == 203);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //  test cyc tick pos dir spd pau nticks
        // 0: free run from reset, period 64, pos 0..3 wrap
        add(0,   0, 0, 0, 0, 0, 0, 0);
        add(0,  62, 0, 0, 0, 0, 0, 0);
        add(0,  63, 1, 0, 0, 0, 0, 1);
        add(0,  64, 0, 1, 0, 0, 0, 1);
        add(0, 127, 1, 1, 0, 0, 0, 2);
        add(0, 128, 0, 2, 0, 0, 0, 2);
        add(0, 191, 1, 2, 0, 0, 0, 3);
        add(0, 192, 0, 3, 0, 0, 0, 3);
        add(0, 255, 1, 3, 0, 0, 0, 4);
        add(0, 256, 0, 0, 0, 0, 0, 4);
        // 1: bouncy speed key -> one event in cycle 5, period 32 from cycle 6
        add(1,   5, 0, 0, 0, 0, 0, 0);
        add(1,   6, 0, 0, 0, 1, 0, 0);
        add(1,  36, 0, 0, 0, 1, 0, 0);
        add(1,  37, 1, 0, 0, 1, 0, 1);
        add(1,  38, 0, 1, 0, 1, 0, 1);
        add(1,  68, 0, 1, 0, 1, 0, 1);
        add(1,  69, 1, 1, 0, 1, 0, 2);
        add(1,  70, 0, 2, 0, 1, 0, 2);
        // 2: dir event coincides with tick at pos=2 (cycle 191)
        add(2, 127, 1, 1, 0, 0, 0, 2);
        add(2, 190, 0, 2, 0, 0, 0, 2);
        add(2, 191, 1, 2, 0, 0, 0, 3);
        add(2, 192, 0, 3, 1, 0, 0, 3);
        add(2, 255, 1, 3, 1, 0, 0, 4);
        add(2, 256, 0, 2, 1, 0, 0, 4);
        add(2, 319, 1, 2, 1, 0, 0, 5);
        add(2, 320, 0, 1, 1, 0, 0, 5);
        // 3: four speed presses, periods 32,16,8,64
        add(3,   6, 0, 0, 0, 1, 0, 0);
        add(3,  36, 0, 0, 0, 1, 0, 0);
        add(3,  37, 1, 0, 0, 1, 0, 1);
        add(3,  69, 1, 1, 0, 1, 0, 2);
        add(3,  75, 0, 2, 0, 1, 0, 2);
        add(3,  76, 0, 2, 0, 2, 0, 2);
        add(3,  90, 0, 2, 0, 2, 0, 2);
        add(3,  91, 1, 2, 0, 2, 0, 3);
        add(3, 107, 1, 3, 0, 2, 0, 4);
        add(3, 114, 0, 0, 0, 3, 0, 4);
        add(3, 121, 1, 0, 0, 3, 0, 5);
        add(3, 129, 1, 1, 0, 3, 0, 6);
        add(3, 136, 0, 2, 0, 0, 0, 6);
        add(3, 198, 0, 2, 0, 0, 0, 6);
        add(3, 199, 1, 2, 0, 0, 0, 7);
        add(3, 200, 0, 3, 0, 0, 0, 7);
        // 4: reset pulse (cycle 203) while speed key in PRESS_WAIT at pos=3
        add(4, 191, 1, 2, 0, 0, 0, 3);
        add(4, 203, 0, 3, 0, 0, 0, 3);
        add(4, 204, 0, 0, 0, 0, 0, 3);
        add(4, 210, 0, 0, 0, 0, 0, 3);
        add(4, 266, 0, 0, 0, 0, 0, 3);
        add(4, 267, 1, 0, 0, 0, 0, 4);
        add(4, 268, 0, 1, 0, 0, 0, 4);
`ifdef LED_STEP_PAUSE_EN
        // 5: pause at pos=1 (prescaler frozen at 12), resume in cycle 586
        add(5,  63, 1, 0, 0, 0, 0, 1);
        add(5,  75, 0, 1, 0, 0, 0, 1);
        add(5,  76, 0, 1, 0, 0, 1, 1);
        add(5, 585, 0, 1, 0, 0, 1, 1);
        add(5, 586, 0, 1, 0, 0, 0, 1);
        add(5, 636, 0, 1, 0, 0, 0, 1);
        add(5, 637, 1, 1, 0, 0, 0, 2);
        add(5, 638, 0, 2, 0, 0, 0, 2);
`endif

        for (int t = 0; t <= 4; t++) run_test(t);
`ifdef LED_STEP_PAUSE_EN
        run_test(5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 The block SHALL have parameter STEP_SHIFT_MAX, default 25; the level-0 step period is 2^STEP_SHIFT_MAX clocks.
REQ-002 The block SHALL have parameter DEB_CYC, default 1000000; it is the key debounce stability time in clocks (20 ms at 50 MHz).
REQ-003 clk_50M  input  1  system clock, 50 MHz.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 key_speed_n  input  1  speed key, active-low, asynchronous to clk_50M.
REQ-006 key_dir_n  input  1  direction key, active-low, asynchronous to clk_50M.
REQ-007 key_pause_n  input  1  pause key, active-low, asynchronous; present only with LED_STEP_PAUSE_EN.
REQ-008 pos  output  2  current LED index (0..3), consumed by the downstream 4-LED chaser decoder.
REQ-009 dir  output  1  0 = pos counts up, 1 = pos counts down.
REQ-010 speed  output  2  current speed level (0 = slowest, 3 = fastest).
REQ-011 step_tick  output  1  one-cycle pulse asserted on the cycle pos updates.
REQ-012 paused  output  1  1 = stepping frozen; present only with LED_STEP_PAUSE_EN.

Function
REQ-013 Each key input SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 Each key SHALL have its own debounce FSM with states IDLE, PRESS_WAIT, HELD and REL_WAIT.
REQ-015 IDLE->PRESS_WAIT on synced low. PRESS_WAIT->HELD after DEB_CYC consecutive low cycles, emitting a one-cycle press event. PRESS_WAIT->IDLE on any high cycle.
REQ-016 HELD->REL_WAIT on synced high. REL_WAIT->IDLE after DEB_CYC consecutive high cycles. REL_WAIT->HELD on any low cycle.
REQ-017 Each key press SHALL emit exactly one event, however long the key is held.
REQ-018 A speed press event SHALL advance speed 0->1->2->3->0 (wrap) in the following cycle.
REQ-019 A direction press event SHALL toggle dir in the following cycle.
REQ-020 The prescaler counter SHALL be STEP_SHIFT_MAX+1 bits wide.
REQ-021 step_tick SHALL assert when the prescaler equals 2^(STEP_SHIFT_MAX-speed)-1; on that cycle the prescaler SHALL return to 0.
REQ-022 On a speed press event the prescaler SHALL clear to 0, so the first tick at the new speed comes one full new period later.
REQ-023 On step_tick, pos SHALL change by +1 if dir=0 or -1 if dir=1, modulo 4 (3->0 up, 0->3 down), taking effect the cycle after the tick.
REQ-024 If a direction press event and step_tick coincide, the tick SHALL use the old dir; the new dir applies from the next tick.
REQ-025 If a speed press event and step_tick coincide, the tick SHALL complete (pos updates) and the prescaler SHALL clear.
REQ-026 Simultaneous events from different keys SHALL all be applied in the same cycle.

Reset
REQ-027 While rst=0, the block SHALL hold pos=0, dir=0, speed=0, step_tick=0 and paused=0.
REQ-028 While rst=0, the prescaler, all synchronizer flops (to 1) and all debounce FSMs (to IDLE with counters 0) SHALL be cleared.
REQ-029 Reset asserted mid-debounce or mid-period SHALL discard all partial progress, with no event or tick emitted.
REQ-030 After rst deasserts, the first step_tick SHALL occur exactly 2^STEP_SHIFT_MAX cycles later.

Configuration
REQ-031 Macro LED_STEP_PAUSE_EN: when defined, key_pause_n and paused exist and a pause press event toggles paused.
REQ-032 With LED_STEP_PAUSE_EN defined and paused=1, the prescaler and pos SHALL hold and step_tick SHALL stay 0; speed and dir presses still apply.
REQ-033 With LED_STEP_PAUSE_EN defined, a speed press while paused SHALL still clear the prescaler.
REQ-034 With LED_STEP_PAUSE_EN undefined, neither port nor any pause logic SHALL exist, and stepping is never frozen.

Verification (STEP_SHIFT_MAX=6, DEB_CYC=4)
REQ-035 Release reset, no keys -> step_tick every 64 cycles; pos 0,1,2,3,0 after ticks 1..4.
REQ-036 Speed key low 4 cycles, then high 3 cycles, then low 10 cycles -> exactly one speed event (speed=1); ticks every 32 cycles, the first 32 cycles after the event.
REQ-037 Direction press landing on the same cycle as a tick with pos=2 -> pos=3 on that tick, then 2, then 1 on the following ticks.
REQ-038 Four speed presses -> speed sequence 1,2,3,0, with tick periods 32,16,8,64.
REQ-039 rst pulsed low for 1 cycle while a key is in PRESS_WAIT at pos=3 -> all outputs 0 and no press event; next tick 64 cycles after release.
REQ-040 With LED_STEP_PAUSE_EN, pause press at pos=1 -> no ticks for 500 cycles; after a second pause press, ticks resume and pos goes to 2.
